// File: rtl/debounce_multi.sv
// Multi-channel key debouncer: per-key synchroniser, stability counter and
// registered press / release / long-press strobes for the front-panel control FSMs.
module debounce_multi #(
  parameter int N_KEYS        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 1000,
  parameter int IDLE_LEVEL    = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] hold_pulse,
  output logic              any_press
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic          IDLE_BIT    = (IDLE_LEVEL != 0);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX    = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_w;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic                   hold_q, hold_d;

    assign s_w = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLOCK) begin
      if (!RESET) begin
        sync_q <= {SYNC_STAGES{IDLE_BIT}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], key_in[i]};
      end
    end

    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      hcnt_d  = hcnt_q;
      hold_d  = 1'b0;

      // Any sample agreeing with the current level restarts the stability window.
      if (s_w == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == STABLE_LAST) begin
        cnt_d   = '0;
        level_d = s_w;
        if (s_w != IDLE_BIT) begin
          press_d = 1'b1;
        end else begin
          rel_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      // Hold counter saturates so a long press yields exactly one hold strobe.
      if (press_d) begin
        hcnt_d = '0;
      end else if (level_q != IDLE_BIT) begin
        if (hcnt_q != LONG_MAX) begin
          hcnt_d = hcnt_q + 1'b1;
          hold_d = (hcnt_q == LONG_LAST);
        end
      end else begin
        hcnt_d = '0;
      end
    end

    always_ff @(posedge CLOCK) begin
      if (!RESET) begin
        cnt_q   <= '0;
        level_q <= IDLE_BIT;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        hcnt_q  <= '0;
        hold_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        hcnt_q  <= hcnt_d;
        hold_q  <= hold_d;
      end
    end

    assign key_out[i]       = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign hold_pulse[i]    = hold_q;
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios with literal expectations plus
// randomized key traffic checked every cycle against a sample-history model.
module tb_debounce_multi;

  localparam int  NK     = 4;
  localparam int  SYNC   = 2;
  localparam int  STABLE = 4;
  localparam int  LONG   = 10;
  localparam logic IDLE  = 1'b1;
  localparam int  W      = 4 * NK + 1;

  logic          CLOCK;
  logic          RESET;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_out;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] hold_pulse;
  logic          any_press;

  debounce_multi #(
    .N_KEYS(NK), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
    .LONG_CYCLES(LONG), .IDLE_LEVEL(1)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .key_in(key_in), .key_out(key_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .hold_pulse(hold_pulse), .any_press(any_press)
  );

  // clock / reset
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model: debounced level flips once the last STABLE synchronised
  // samples all disagree with it; hold fires LONG cycles after an unbroken press
  logic [W-1:0]  exp_q[$];
  logic [NK-1:0] hist_q[$];
  int            cyc      = 0;
  int            last_rst = -1;
  logic [NK-1:0] m_ko;
  int            pe[NK];

  function automatic logic s_at(input int t, input int ch);
    int idx;
    idx = t - SYNC;
    if (idx < 0 || idx <= last_rst) return IDLE;
    return hist_q[idx][ch];
  endfunction

  initial begin
    logic [NK-1:0] mp, mr, mh;
    logic          flip, old;
    m_ko = '1;
    for (int c = 0; c < NK; c++) pe[c] = -1;
    forever begin
      @(posedge CLOCK);
      hist_q.push_back(key_in);
      mp = '0; mr = '0; mh = '0;
      if (!RESET) begin
        last_rst = cyc;
        m_ko = '1;
        for (int c = 0; c < NK; c++) pe[c] = -1;
      end else begin
        for (int c = 0; c < NK; c++) begin
          old = m_ko[c];
          if (old != IDLE && pe[c] >= 0 && cyc - pe[c] == LONG) mh[c] = 1'b1;
          flip = 1'b1;
          for (int k = 0; k < STABLE; k++)
            if (s_at(cyc - k, c) == old) flip = 1'b0;
          if (flip) begin
            m_ko[c] = ~old;
            if (m_ko[c] != IDLE) begin
              mp[c] = 1'b1;
              pe[c] = cyc;
            end else begin
              mr[c] = 1'b1;
              pe[c] = -1;
            end
          end
        end
      end
      exp_q.push_back({m_ko, mp, mr, mh, |mp});
      cyc++;
    end
  end

  // scoreboard compare, away from the active edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge CLOCK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("key_out",       32'(key_out),       32'(e[W-1 -: NK]));
        chk("press_pulse",   32'(press_pulse),   32'(e[3*NK -: NK]));
        chk("release_pulse", 32'(release_pulse), 32'(e[2*NK -: NK]));
        chk("hold_pulse",    32'(hold_pulse),    32'(e[NK -: NK]));
        chk("any_press",     32'(any_press),     32'(e[0]));
      end
    end
  end

  // pulse counters for the directed count checks
  int pc_press[NK], pc_rel[NK], pc_hold[NK];
  initial begin
    for (int c = 0; c < NK; c++) begin pc_press[c] = 0; pc_rel[c] = 0; pc_hold[c] = 0; end
    forever begin
      @(negedge CLOCK);
      for (int c = 0; c < NK; c++) begin
        pc_press[c] += int'(press_pulse[c]);
        pc_rel[c]   += int'(release_pulse[c]);
        pc_hold[c]  += int'(hold_pulse[c]);
      end
    end
  end

  task automatic clear_counts();
    for (int c = 0; c < NK; c++) begin pc_press[c] = 0; pc_rel[c] = 0; pc_hold[c] = 0; end
  endtask

  // driver tasks
  task automatic wait_n(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  initial begin
    logic [6:0] pat;
    int         rem[NK];
    RESET  = 1'b0;
    key_in = 4'b0000;

    // reset with keys low, then release: all keys debounce to pressed
    wait_n(3);
    chk("rst_key_out", 32'(key_out), 32'hF);
    chk("rst_press",   32'(press_pulse), 32'h0);
    RESET = 1'b1;
    wait_n(5);
    chk("s1_key_out_pre", 32'(key_out), 32'hF);
    wait_n(1);
    chk("s1_key_out",  32'(key_out), 32'h0);
    chk("s1_press",    32'(press_pulse), 32'hF);
    chk("s1_any",      32'(any_press), 32'h1);
    wait_n(1);
    chk("s1_press_end", 32'(press_pulse), 32'h0);
    chk("s1_any_end",   32'(any_press), 32'h0);
    key_in = 4'hF;
    wait_n(12);

    // clean press, hold and release on key0
    key_in = 4'b1110;
    wait_n(5);
    chk("s2_ko_pre", 32'(key_out[0]), 32'h1);
    wait_n(1);
    chk("s2_ko",     32'(key_out[0]), 32'h0);
    chk("s2_press",  32'(press_pulse[0]), 32'h1);
    wait_n(9);
    chk("s2_hold_pre", 32'(hold_pulse[0]), 32'h0);
    wait_n(1);
    chk("s2_hold",     32'(hold_pulse[0]), 32'h1);
    wait_n(1);
    chk("s2_hold_end", 32'(hold_pulse[0]), 32'h0);
    key_in = 4'hF;
    wait_n(5);
    chk("s2_rel_pre", 32'(release_pulse[0]), 32'h0);
    wait_n(1);
    chk("s2_rel",     32'(release_pulse[0]), 32'h1);
    wait_n(8);

    // bounce on key1 never reaches four stable samples
    clear_counts();
    pat = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      key_in[1] = pat[i];
      wait_n(1);
    end
    key_in = 4'hF;
    wait_n(10);
    chk("s3_ko_bounce",    32'(key_out[1]), 32'h1);
    chk("s3_press_bounce", 32'(pc_press[1]), 32'd0);
    key_in[1] = 1'b0;
    wait_n(6);
    chk("s3_ko_stable", 32'(key_out[1]), 32'h0);
    key_in = 4'hF;
    wait_n(12);

    // short press on key2: press and release once, no hold
    clear_counts();
    key_in[2] = 1'b0;
    wait_n(8);
    key_in = 4'hF;
    wait_n(20);
    chk("s4_press_cnt", 32'(pc_press[2]), 32'd1);
    chk("s4_rel_cnt",   32'(pc_rel[2]),   32'd1);
    chk("s4_hold_cnt",  32'(pc_hold[2]),  32'd0);

    // reset mid-count on key3, key still down afterwards
    clear_counts();
    key_in[3] = 1'b0;
    wait_n(2);
    RESET = 1'b0;
    wait_n(2);
    chk("s5_ko_rst", 32'(key_out[3]), 32'h1);
    RESET = 1'b1;
    wait_n(5);
    chk("s5_press_pre", 32'(press_pulse[3]), 32'h0);
    wait_n(1);
    chk("s5_press",     32'(press_pulse[3]), 32'h1);
    key_in = 4'hF;
    wait_n(12);

    // simultaneous press of key0 and key3
    key_in = 4'b0110;
    wait_n(6);
    chk("s6_press", 32'(press_pulse), 32'h9);
    chk("s6_any",   32'(any_press), 32'h1);
    wait_n(1);
    chk("s6_any_end", 32'(any_press), 32'h0);
    key_in = 4'hF;
    wait_n(15);

    // randomized traffic: random levels held 1..18 cycles, rare resets
    for (int c = 0; c < NK; c++) rem[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NK; c++) begin
        if (rem[c] == 0) begin
          key_in[c] = 1'($urandom_range(0, 1));
          rem[c]    = $urandom_range(1, 18);
        end
        rem[c]--;
      end
      RESET = ($urandom_range(0, 599) != 0);
      wait_n(1);
    end
    RESET  = 1'b1;
    key_in = 4'hF;
    wait_n(20);
    chk("final_key_out", 32'(key_out), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
